// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide sequencer: word types, funct
// codes, the sequencer state encoding and small funct-decoding helpers.
package mips_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 6;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [2*XLEN-1:0] dword_t;

  // R-format funct codes handled by the HI/LO unit
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  // Counter value of the final iteration
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } md_state_e;

  // mult/multu/div/divu occupy 0x18..0x1B
  function automatic logic is_muldiv(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

  // mfhi/mthi/mflo/mtlo occupy 0x10..0x13
  function automatic logic is_hilo_move(input logic [5:0] f);
    return f[5:2] == 4'b0100;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath (combinational).
//   acc_i     : {upper, lower} accumulator
//               multiply: {partial product, remaining multiplier bits}
//               divide  : {partial remainder, dividend/quotient bits}
//   operand_i : multiplicand (multiply) or divisor (divide), unsigned
//   div_i     : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_o     : accumulator after this iteration
module muldiv_step
  import mips_pkg::*;
(
  input  dword_t acc_i,
  input  word_t  operand_i,
  input  logic   div_i,
  output dword_t acc_o
);

  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   rem_shift;
  logic            rem_fits;
  word_t           rem_sub;

  always_comb begin
    // Multiply: add the multiplicand when the current multiplier bit is set,
    // then shift the 65-bit {carry, acc} right by one.
    add_sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + ({1'b0, operand_i} & {(XLEN+1){acc_i[0]}});

    // Divide: remainder shifted left (33 bits so nothing is lost), trial subtract.
    // When the subtract succeeds the difference is below the divisor, so the
    // low 32 bits of the modular difference are exact.
    rem_shift = acc_i[2*XLEN-1:XLEN-1];
    rem_fits  = rem_shift >= {1'b0, operand_i};
    rem_sub   = acc_i[2*XLEN-2:XLEN-1] - operand_i;

    if (div_i) begin
      if (rem_fits) begin
        acc_o = {rem_sub, acc_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = {acc_i[2*XLEN-2:0], 1'b0};
      end
    end else begin
      acc_o = {add_sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_controller.sv
// Multi-cycle multiply/divide sequencer owning the architectural HI/LO.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start, funct    : EX-stage instruction valid + funct field
//   opA, opB        : forwarded rs / rt operands
//   stall           : freeze front of pipeline (combinational)
//   done, divZero   : completion pulse, divide-by-zero flag with it
//   result          : HI for mfhi, LO for mflo, else 0 (combinational)
//   hi, lo          : architectural HI/LO registers
module muldiv_controller
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  output logic        stall,
  output logic        done,
  output logic        divZero,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dword_t           acc_q, acc_d;
  word_t            opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  word_t            hi_q, hi_d;
  word_t            lo_q, lo_d;
  logic             divzero_q, divzero_d;

  logic             busy;
  logic             can_accept;
  logic             new_signed;
  logic             new_sa;
  logic             new_sb;
  word_t            abs_a;
  word_t            abs_b;
  dword_t           step_acc;
  dword_t           prod_fix;
  word_t            quo_fix;
  word_t            rem_fix;

  // Sign extraction and magnitudes for a newly accepted operation
  assign new_signed = ~funct[0];
  assign new_sa     = new_signed & opA[XLEN-1];
  assign new_sb     = new_signed & opB[XLEN-1];
  assign abs_a      = new_sa ? word_t'(-opA) : opA;
  assign abs_b      = new_sb ? word_t'(-opB) : opB;

  assign busy       = (state_q == PREP) || (state_q == RUN) || (state_q == FIX);
  assign can_accept = start && ((state_q == IDLE) || (state_q == DONE));

  muldiv_step u_step (
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .div_i     (is_div_q),
    .acc_o     (step_acc)
  );

  // Final sign correction of the unsigned result held in the accumulator
  assign prod_fix = (sa_q ^ sb_q) ? dword_t'(-acc_q) : acc_q;
  assign quo_fix  = (sa_q ^ sb_q) ? word_t'(-acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
  assign rem_fix  = sa_q ? word_t'(-acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    divzero_d = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (can_accept && is_muldiv(funct)) begin
          state_d  = PREP;
          cnt_d    = '0;
          is_div_d = funct[1];
          sa_d     = new_sa;
          sb_d     = new_sb;
          // Multiply keeps the multiplier in the low word; divide keeps the dividend
          acc_d    = funct[1] ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
          opnd_d   = funct[1] ? abs_b : abs_a;
        end else if (can_accept && (funct == F_MTHI)) begin
          hi_d = opA;
        end else if (can_accept && (funct == F_MTLO)) begin
          lo_d = opA;
        end
      end

      PREP: begin
        if (is_div_q && (opnd_q == '0)) begin
          state_d   = DONE;
          divzero_d = 1'b1;
        end else begin
          state_d = RUN;
        end
      end

      RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = FIX;
        end
      end

      FIX: begin
        state_d = DONE;
        if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[2*XLEN-1:XLEN];
          lo_d = prod_fix[XLEN-1:0];
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      divzero_q <= divzero_d;
    end
  end

  // Stall: sequencer busy, a mult/div being accepted from IDLE, or a HI/LO
  // move arriving while busy (subsumed by busy, kept for clarity).
  assign stall = busy
               || (start && (state_q == IDLE) && is_muldiv(funct))
               || (start && is_hilo_move(funct) && busy);

  assign done    = (state_q == DONE);
  assign divZero = divzero_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

  assign result = (start && (funct == F_MFHI)) ? hi_q :
                  (start && (funct == F_MFLO)) ? lo_q : '0;

endmodule

// File: tb/tb_muldiv_controller.sv
// Self-checking bench for muldiv_controller: reset values, a table of known
// vectors, hand-written multi-cycle sequences and randomized operations
// checked against an arithmetic reference model.
module tb_muldiv_controller;
  import mips_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        stall;
  logic        done;
  logic        divZero;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors;
  int checks;

  logic [31:0] mh;
  logic [31:0] ml;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t vecs[8];

  muldiv_controller dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .funct   (funct),
    .opA     (opA),
    .opB     (opB),
    .stall   (stall),
    .done    (done),
    .divZero (divZero),
    .result  (result),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural values
  task automatic ref_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ph, input logic [31:0] pl,
                           output logic [31:0] eh, output logic [31:0] el, output bit dz);
    longint          sa;
    longint          sb;
    longint          q;
    longint          r;
    longint unsigned p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = ph;
    el = pl;
    dz = 1'b0;
    case (f)
      F_MULT:  begin q = sa * sb; eh = q[63:32]; el = q[31:0]; end
      F_MULTU: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; end
      F_DIV: begin
        if (b == 32'd0) dz = 1'b1;
        else begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
      end
      F_DIVU: begin
        if (b == 32'd0) dz = 1'b1;
        else begin el = a / b; eh = a % b; end
      end
      F_MTHI:  eh = a;
      F_MTLO:  el = a;
      default: ;
    endcase
  endtask

  // Present a mult/div at a negedge and hold it until done; lat = cycles to DONE
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic stall0, output int lat);
    int drops;
    start = 1'b1; funct = f; opA = a; opB = b;
    #1;
    chk("stall_cycle0", 32'(stall), 32'(stall0));
    lat   = 0;
    drops = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      if (!stall) drops++;
    end
    if (lat == 0) begin
      errors++;
      checks++;
      $display("FAIL done_timeout: got no done within 100 cycles expected done");
    end
    chk("stall_while_busy_drops", 32'(drops), 32'd0);
    chk("stall_in_done", 32'(stall), 32'd0);
  endtask

  // Drop start after DONE and confirm the pulse lasts one cycle
  task automatic finish_op();
    start = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("divzero_one_cycle", 32'(divZero), 32'd0);
  endtask

  task automatic move_to(input logic [5:0] f, input logic [31:0] a);
    start = 1'b1; funct = f; opA = a; opB = 32'd0;
    #1;
    chk("mt_no_stall", 32'(stall), 32'd0);
    @(negedge clk);
    if (f == F_MTHI) chk("mthi_hi", hi, a);
    else             chk("mtlo_lo", lo, a);
    start = 1'b0;
  endtask

  initial begin
    int          lat;
    int          drops;
    int          pulses;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    bit          dz;
    logic [5:0]  ops[8];

    errors = 0;
    checks = 0;
    rst = 1'b1; start = 1'b0; funct = 6'd0; opA = 32'd0; opB = 32'd0;

    vecs[0] = '{F_MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{F_DIVU,  32'd100,        32'd7,         32'd2,         32'd14};
    vecs[2] = '{F_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{F_MULT,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[4] = '{F_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{F_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[6] = '{F_DIVU,  32'hFFFF_FFFF,  32'd1,         32'h0000_0000, 32'hFFFF_FFFF};
    vecs[7] = '{F_DIV,   32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

    ops[0] = F_MULT; ops[1] = F_MULTU; ops[2] = F_DIV;  ops[3] = F_DIVU;
    ops[4] = F_MTHI; ops[5] = F_MTLO;  ops[6] = F_MFHI; ops[7] = F_MFLO;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_divzero", 32'(divZero), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_result", result, 32'd0);
    @(negedge clk);

    // Table of known vectors
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b, 1'b1, lat);
      chk("vec_latency", 32'(lat), 32'd35);
      chk("vec_hi", hi, vecs[i].eh);
      chk("vec_lo", lo, vecs[i].el);
      chk("vec_divzero", 32'(divZero), 32'd0);
      chk("vec_result_nonmove", result, 32'd0);
      finish_op();
    end
    mh = vecs[7].eh;
    ml = vecs[7].el;

    // Divide by zero keeps preloaded HI/LO
    move_to(F_MTHI, 32'h55);
    move_to(F_MTLO, 32'hAA);
    issue(F_DIV, 32'd1234, 32'd0, 1'b1, lat);
    chk("div0_latency", 32'(lat), 32'd2);
    chk("div0_flag", 32'(divZero), 32'd1);
    chk("div0_hi", hi, 32'h55);
    chk("div0_lo", lo, 32'hAA);
    finish_op();
    mh = 32'h55;
    ml = 32'hAA;

    // mfhi presented from cycle 1 of a mult: stalled through FIX, valid in DONE
    ref_model(F_MULT, 32'h1234_5678, 32'h9ABC_DEF0, mh, ml, eh, el, dz);
    start = 1'b1; funct = F_MULT; opA = 32'h1234_5678; opB = 32'h9ABC_DEF0;
    @(negedge clk);
    funct = F_MFHI;
    lat = 0;
    drops = 0;
    for (int i = 1; i <= 100; i++) begin
      #1;
      if (done) begin
        lat = i;
        break;
      end
      if (!stall) drops++;
      @(negedge clk);
    end
    chk("mfhi_busy_latency", 32'(lat), 32'd35);
    chk("mfhi_busy_stall_drops", 32'(drops), 32'd0);
    chk("mfhi_done_stall", 32'(stall), 32'd0);
    chk("mfhi_done_result", result, eh);
    finish_op();
    mh = eh;
    ml = el;

    // Back-to-back with start held in DONE
    issue(F_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1, lat);
    chk("b2b_first_latency", 32'(lat), 32'd35);
    chk("b2b_first_hi", hi, 32'h4000_0000);
    chk("b2b_first_lo", lo, 32'h0000_0000);
    issue(F_MULT, 32'd3, 32'd4, 1'b0, lat);
    chk("b2b_second_latency", 32'(lat), 32'd35);
    chk("b2b_second_lo", lo, 32'd12);
    chk("b2b_second_hi", hi, 32'd0);
    issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat);
    chk("b2b_third_latency", 32'(lat), 32'd35);
    chk("b2b_third_lo", lo, 32'h8000_0000);
    chk("b2b_third_hi", hi, 32'h0000_0000);
    finish_op();
    mh = 32'h0;
    ml = 32'h8000_0000;

    // Randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      f = ops[$urandom_range(0, 7)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000_000F;
      if ($urandom_range(0, 9) == 0) b = 32'd0;
      ref_model(f, a, b, mh, ml, eh, el, dz);
      if (is_muldiv(f)) begin
        issue(f, a, b, 1'b1, lat);
        chk("rnd_latency", 32'(lat), dz ? 32'd2 : 32'd35);
        chk("rnd_hi", hi, eh);
        chk("rnd_lo", lo, el);
        chk("rnd_divzero", 32'(divZero), 32'(dz));
        finish_op();
      end else if ((f == F_MTHI) || (f == F_MTLO)) begin
        move_to(f, a);
        chk("rnd_mt_hi", hi, eh);
        chk("rnd_mt_lo", lo, el);
      end else begin
        start = 1'b1; funct = f; opA = a; opB = b;
        #1;
        chk("rnd_mf_stall", 32'(stall), 32'd0);
        chk("rnd_mf_result", result, (f == F_MFHI) ? mh : ml);
        @(negedge clk);
        start = 1'b0;
      end
      mh = eh;
      ml = el;
    end

    // Reset in the middle of a divide
    if (hi == 32'd0) move_to(F_MTHI, 32'hDEAD_BEEF);
    if (lo == 32'd0) move_to(F_MTLO, 32'hCAFE_F00D);
    start = 1'b1; funct = F_DIV; opA = 32'd1000; opB = 32'd3;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("rst_mid_no_done", 32'(pulses), 32'd0);
    chk("rst_mid_idle_stall", 32'(stall), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
